calc_result_display: RTL and testbench

Sequential back end for the 1-digit calculator datapath. It captures one 8-bit calculator result together with its op code and error flag. It converts the magnitude to three BCD digits with an iterative double-dabble engine (one shift per clock) and drives a time-multiplexed 4-digit active-low 7-segment display: sign, hundreds, tens, ones, or "Err".

---
 rtl/calc_pkg.sv | 38 +++
 rtl/calc_seg_encode.sv | 29 ++
 rtl/calc_result_display.sv | 161 ++++++++++++++++
 tb/tb_calc_result_display.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared op codes, FSM states, glyph codes and active-low segment patterns
// for the calculator result display.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } state_t;

    // Glyph codes 0..9 are the decimal digits themselves.
    localparam logic [4:0] GLYPH_MINUS = 5'd10;
    localparam logic [4:0] GLYPH_E     = 5'd11;
    localparam logic [4:0] GLYPH_R     = 5'd12;
    localparam logic [4:0] GLYPH_BLANK = 5'd13;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/calc_seg_encode.sv
// Combinational glyph-to-segment lookup; unknown codes render blank.
module calc_seg_encode
    import calc_pkg::*;
(
    input  logic [4:0] glyph_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (glyph_i)
            5'd0:        seg_o = SEG_0;
            5'd1:        seg_o = SEG_1;
            5'd2:        seg_o = SEG_2;
            5'd3:        seg_o = SEG_3;
            5'd4:        seg_o = SEG_4;
            5'd5:        seg_o = SEG_5;
            5'd6:        seg_o = SEG_6;
            5'd7:        seg_o = SEG_7;
            5'd8:        seg_o = SEG_8;
            5'd9:        seg_o = SEG_9;
            GLYPH_MINUS: seg_o = SEG_MINUS;
            GLYPH_E:     seg_o = SEG_E;
            GLYPH_R:     seg_o = SEG_R;
            default:     seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_result_display.sv
// Captures a calculator result, converts its magnitude to BCD one bit per
// clock (double dabble) and scans it onto a 4-digit active-low 7-seg display.
module calc_result_display
    import calc_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] result,
    input  logic [1:0] op,
    input  logic       error,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       neg,
    output logic       err,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t           state_q;
    logic             busy_q, done_q;
    logic [3:0]       hund_q, tens_q, ones_q;
    logic             neg_q, err_q;
    logic             wneg_q, werr_q;
    logic [11:0]      bcd_q, bcd_d;
    logic [7:0]       mag_q, mag_d;
    logic [2:0]       bit_q;
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q;
    logic [6:0]       seg_q, seg_d;
    logic             neg_n;
    logic [7:0]       mag_n;
    logic [11:0]      bcd_adj;
    logic [4:0]       glyph;

    always_comb begin
        neg_n = (op == OP_SUB) && result[7] && !error;
        mag_n = neg_n ? (~result + 8'd1) : result;
    end

    // Add-3 correction happens before the shift within the same cycle.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        bcd_d = {bcd_adj[10:0], mag_q[7]};
        mag_d = {mag_q[6:0], 1'b0};
    end

    always_comb begin
        refresh_d = (refresh_q == CNT_LAST) ? '0 : refresh_q + CNT_W'(1);
        idx_d     = (refresh_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
    end

    always_comb begin
        glyph = GLYPH_BLANK;
        if (err_q) begin
            case (idx_d)
                2'd3:    glyph = GLYPH_BLANK;
                2'd2:    glyph = GLYPH_E;
                default: glyph = GLYPH_R;
            endcase
        end else begin
            case (idx_d)
                2'd3:    glyph = neg_q ? GLYPH_MINUS : GLYPH_BLANK;
                2'd2:    glyph = (hund_q == 4'd0) ? GLYPH_BLANK : {1'b0, hund_q};
                2'd1:    glyph = (hund_q == 4'd0 && tens_q == 4'd0) ? GLYPH_BLANK
                                                                     : {1'b0, tens_q};
                default: glyph = {1'b0, ones_q};
            endcase
        end
    end

    calc_seg_encode u_seg_encode (
        .glyph_i (glyph),
        .seg_o   (seg_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hund_q    <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            wneg_q    <= 1'b0;
            werr_q    <= 1'b0;
            bcd_q     <= '0;
            mag_q     <= '0;
            bit_q     <= '0;
            refresh_q <= '0;
            idx_q     <= '0;
            an_q      <= 4'b1110;
            seg_q     <= SEG_0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        werr_q  <= error;
                        wneg_q  <= neg_n;
                        mag_q   <= mag_n;
                        bcd_q   <= '0;
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd_q <= bcd_d;
                    mag_q <= mag_d;
                    bit_q <= bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    hund_q  <= werr_q ? 4'd0 : bcd_q[11:8];
                    tens_q  <= werr_q ? 4'd0 : bcd_q[7:4];
                    ones_q  <= werr_q ? 4'd0 : bcd_q[3:0];
                    neg_q   <= wneg_q;
                    err_q   <= werr_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            an_q      <= ~(4'b0001 << idx_d);
            seg_q     <= seg_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_hund = hund_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;
    assign neg      = neg_q;
    assign err      = err_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display with a short refresh period.
module tb_calc_result_display;

    logic       clk = 1'b0;
    logic       rst_n, start, error;
    logic [7:0] result;
    logic [1:0] op;
    logic       busy, done, neg, err;
    logic [3:0] bcd_hund, bcd_tens, bcd_ones, an;
    logic [6:0] seg;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    calc_result_display #(.REFRESH_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .result   (result),
        .op       (op),
        .error    (error),
        .busy     (busy),
        .done     (done),
        .bcd_hund (bcd_hund),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
        .neg      (neg),
        .err      (err),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one conversion and measure the edges until done appears.
    task automatic run_conv(input logic [7:0] r, input logic [1:0] o, input logic e);
        int unsigned n;
        result = r;
        op     = o;
        error  = e;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        n = 21;
        for (int unsigned i = 1; i <= 20; i++) begin
            tick();
            if (i == 8) check("busy_last_conv", busy, 1);
            if (done) begin
                n = i;
                break;
            end
        end
        check("done_latency", n, 9);
        check("busy_at_done", busy, 0);
    endtask

    task automatic seg_at(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
        int unsigned found = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            if (an == an_exp) begin
                found = 1;
                break;
            end
        end
        check({tag, "_found"}, found, 1);
        check(tag, seg, seg_exp);
    endtask

    initial begin
        int unsigned dones;
        logic [3:0] an_exp;
        rst_n  = 1'b0;
        start  = 1'b0;
        result = '0;
        op     = '0;
        error  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1000000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h000);
        check("rst_neg_err", {neg, err}, 2'b00);

        for (int unsigned j = 0; j <= 16; j++) begin
            if (j > 0) tick();
            case ((j / 4) % 4)
                0:       an_exp = 4'b1110;
                1:       an_exp = 4'b1101;
                2:       an_exp = 4'b1011;
                default: an_exp = 4'b0111;
            endcase
            check("an_seq", an, an_exp);
        end

        run_conv(8'd225, 2'b10, 1'b0);
        check("u225_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h225);
        check("u225_neg", neg, 0);
        seg_at("u225_idx0", 4'b1110, 7'b0010010);
        seg_at("u225_idx2", 4'b1011, 7'b0100100);

        run_conv(8'hFE, 2'b01, 1'b0);
        check("sub_neg", neg, 1);
        check("sub_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h002);
        seg_at("sub_idx3", 4'b0111, 7'b0111111);
        seg_at("sub_idx2", 4'b1011, 7'b1111111);
        seg_at("sub_idx1", 4'b1101, 7'b1111111);
        seg_at("sub_idx0", 4'b1110, 7'b0100100);

        run_conv(8'hFE, 2'b10, 1'b0);
        check("u254_neg", neg, 0);
        check("u254_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h254);

        run_conv(8'h00, 2'b11, 1'b1);
        check("err_flag", err, 1);
        check("err_neg", neg, 0);
        check("err_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h000);
        seg_at("err_idx3", 4'b0111, 7'b1111111);
        seg_at("err_idx2", 4'b1011, 7'b0000110);
        seg_at("err_idx1", 4'b1101, 7'b0101111);
        seg_at("err_idx0", 4'b1110, 7'b0101111);

        // Second start mid-conversion must be dropped.
        result = 8'd57;
        op     = 2'b00;
        error  = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        result = 8'd99;
        start  = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        check("ignore_start_dones", dones, 1);
        check("ignore_start_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h057);

        // Reset landing on the 4th conversion edge.
        result = 8'd130;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h000);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_an", an, 4'b1110);
        check("midrst_seg", seg, 7'b1000000);
        dones = 0;
        for (int unsigned i = 0; i < 15; i++) begin
            tick();
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        check("midrst_bcd_hold", {bcd_hund, bcd_tens, bcd_ones}, 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
